// File: rtl/add_sub_32_checker.sv
// Response monitor for add_sub_32: predicts {Co,S} from the sampled inputs, compares after
// LATENCY edges, and keeps saturating pass/error counts plus a first-mismatch snapshot.
module add_sub_32_checker #(
    parameter int unsigned LATENCY      = 1,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Ci,
    input  logic        Subtract,
    input  logic [31:0] S,
    input  logic        Co,
    output logic        check_valid,
    output logic        mismatch,
    output logic [15:0] chk_count,
    output logic [15:0] err_count,
    output logic [32:0] first_exp,
    output logic [32:0] first_got,
    output logic        first_valid,
    output logic        halted
);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e              r_state;
    state_e              w_state_next;

    logic [LATENCY-1:0]  r_pipe_vld;
    logic [32:0]         r_pipe_dat [LATENCY];

    logic                r_check_valid;
    logic                r_mismatch;
    logic [15:0]         r_chk_count;
    logic [15:0]         r_err_count;
    logic [32:0]         r_first_exp;
    logic [32:0]         r_first_got;
    logic                r_first_valid;

    logic [32:0]         w_ref;
    logic [32:0]         w_got;
    logic [32:0]         w_exp;
    logic                w_capture;
    logic                w_cmp;
    logic                w_mis;
    logic                w_fail_stop;
    logic                w_flush;

    // 33-bit add keeps the carry; subtract is A + ~B + Ci
    assign w_ref       = {1'b0, A} + {1'b0, (Subtract ? ~B : B)} + {32'd0, Ci};
    assign w_got       = {Co, S};
    assign w_exp       = r_pipe_dat[LATENCY-1];
    assign w_capture   = en && (r_state != StHalt);
    assign w_cmp       = r_pipe_vld[LATENCY-1] && (r_state != StHalt);
    assign w_mis       = (w_exp != w_got);
    assign w_fail_stop = STOP_ON_FAIL && w_cmp && w_mis;
    // Entering HALT drops everything still in flight, including this edge's capture
    assign w_flush     = w_fail_stop || (r_state == StHalt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (en)          w_state_next = StRun;
            StRun:   if (w_fail_stop) w_state_next = StHalt;
            StHalt:  w_state_next = StHalt;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        halted = (r_state == StHalt);
    end

    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_capture;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_pipe_dat[0] <= w_ref;
        for (int i = 1; i < int'(LATENCY); i++) begin
            r_pipe_dat[i] <= r_pipe_dat[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_check_valid <= 1'b0;
            r_mismatch    <= 1'b0;
            r_chk_count   <= '0;
            r_err_count   <= '0;
            r_first_exp   <= '0;
            r_first_got   <= '0;
            r_first_valid <= 1'b0;
        end else begin
            r_check_valid <= w_cmp;
            r_mismatch    <= w_cmp && w_mis;
            if (w_cmp && (r_chk_count != 16'hFFFF)) begin
                r_chk_count <= r_chk_count + 16'd1;
            end
            if (w_cmp && w_mis && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
            if (w_cmp && w_mis && !r_first_valid) begin
                r_first_exp   <= w_exp;
                r_first_got   <= w_got;
                r_first_valid <= 1'b1;
            end
        end
    end

    assign check_valid = r_check_valid;
    assign mismatch    = r_mismatch;
    assign chk_count   = r_chk_count;
    assign err_count   = r_err_count;
    assign first_exp   = r_first_exp;
    assign first_got   = r_first_got;
    assign first_valid = r_first_valid;

endmodule

// File: tb/tb_add_sub_32_checker.sv
// Bench for add_sub_32_checker: two instances (LATENCY=1 halting, LATENCY=3 free-running) fed by
// a delayed reference DUT, checked every cycle against a transaction-queue model.
module tb_add_sub_32_checker;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] A;
    logic [31:0] B;
    logic        Ci;
    logic        Subtract;
    logic [31:0] S1, S3;
    logic        Co1, Co3;

    logic        cv1, mm1, fv1, hl1;
    logic        cv3, mm3, fv3, hl3;
    logic [15:0] chk1, err1, chk3, err3;
    logic [32:0] fexp1, fgot1, fexp3, fgot3;

    int n_checks;
    int n_errors;
    int cyc;

    logic [32:0] res1 [0:4095];
    logic [32:0] res3 [0:4095];

    typedef struct {
        int          inst;
        int          due;
        logic [32:0] exp;
    } txn_t;
    txn_t pend[$];

    int          lat  [2] = '{1, 3};
    bit          stop [2] = '{1'b1, 1'b0};
    logic        e_cv [2];
    logic        e_mm [2];
    int          m_chk[2];
    int          m_err[2];
    logic        m_fv [2];
    logic [32:0] m_fexp[2];
    logic [32:0] m_fgot[2];
    logic        m_halt[2];

    add_sub_32_checker #(.LATENCY(1), .STOP_ON_FAIL(1'b1)) u_chk1 (
        .clk(clk), .rst(rst), .en(en), .A(A), .B(B), .Ci(Ci), .Subtract(Subtract),
        .S(S1), .Co(Co1), .check_valid(cv1), .mismatch(mm1), .chk_count(chk1),
        .err_count(err1), .first_exp(fexp1), .first_got(fgot1), .first_valid(fv1),
        .halted(hl1)
    );

    add_sub_32_checker #(.LATENCY(3), .STOP_ON_FAIL(1'b0)) u_chk3 (
        .clk(clk), .rst(rst), .en(en), .A(A), .B(B), .Ci(Ci), .Subtract(Subtract),
        .S(S3), .Co(Co3), .check_valid(cv3), .mismatch(mm3), .chk_count(chk3),
        .err_count(err3), .first_exp(fexp3), .first_got(fgot3), .first_valid(fv3),
        .halted(hl3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Plain integer arithmetic: A-B as 2^32 + A - B - 1 + Ci for subtract
    function automatic logic [32:0] model_ref(input logic [31:0] a, input logic [31:0] b,
                                              input logic ci, input logic sub);
        longint unsigned ta, tb, tc, t;
        ta = longint'(a);
        tb = longint'(b);
        tc = longint'(ci);
        if (sub) t = 64'h1_0000_0000 + ta - tb - 1 + tc;
        else     t = ta + tb + tc;
        return t[32:0];
    endfunction

    task automatic drop_inst(input int k);
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].inst == k) pend.delete(i);
        end
    endtask

    task automatic model_edge(input int k, input logic [32:0] got, input logic en_v,
                              input logic [32:0] exp, input logic rst_v);
        int   idx;
        txn_t t;
        e_cv[k] = 1'b0;
        e_mm[k] = 1'b0;
        if (rst_v) begin
            drop_inst(k);
            m_chk[k] = 0; m_err[k] = 0; m_fv[k] = 1'b0;
            m_fexp[k] = '0; m_fgot[k] = '0; m_halt[k] = 1'b0;
            return;
        end
        if (!m_halt[k]) begin
            idx = -1;
            foreach (pend[i]) if (idx < 0 && pend[i].inst == k) idx = i;
            if (idx >= 0 && pend[idx].due == cyc) begin
                t = pend[idx];
                pend.delete(idx);
                e_cv[k] = 1'b1;
                e_mm[k] = (t.exp != got);
                if (m_chk[k] < 65535) m_chk[k]++;
                if (e_mm[k]) begin
                    if (m_err[k] < 65535) m_err[k]++;
                    if (!m_fv[k]) begin
                        m_fv[k] = 1'b1; m_fexp[k] = t.exp; m_fgot[k] = got;
                    end
                    if (stop[k]) begin
                        m_halt[k] = 1'b1;
                        drop_inst(k);
                    end
                end
            end
        end
        if (en_v && !m_halt[k]) begin
            t.inst = k; t.due = cyc + lat[k]; t.exp = exp;
            pend.push_back(t);
        end
    endtask

    task automatic check_inst(input int k, input logic cv, input logic mm, input logic [15:0] c,
                              input logic [15:0] e, input logic [32:0] fe, input logic [32:0] fg,
                              input logic fv, input logic hl);
        check_eq($sformatf("u%0d.check_valid", lat[k]), 64'(cv), 64'(e_cv[k]));
        check_eq($sformatf("u%0d.mismatch", lat[k]), 64'(mm), 64'(e_mm[k]));
        check_eq($sformatf("u%0d.chk_count", lat[k]), 64'(c), 64'(m_chk[k]));
        check_eq($sformatf("u%0d.err_count", lat[k]), 64'(e), 64'(m_err[k]));
        check_eq($sformatf("u%0d.first_exp", lat[k]), 64'(fe), 64'(m_fexp[k]));
        check_eq($sformatf("u%0d.first_got", lat[k]), 64'(fg), 64'(m_fgot[k]));
        check_eq($sformatf("u%0d.first_valid", lat[k]), 64'(fv), 64'(m_fv[k]));
        check_eq($sformatf("u%0d.halted", lat[k]), 64'(hl), 64'(m_halt[k]));
    endtask

    // One clock edge; ovr replaces the reference DUT's result, c1/c3 flip S[0] per instance
    task automatic step(input logic rst_v, input logic en_v, input logic [31:0] a = 0,
                        input logic [31:0] b = 0, input logic ci = 0, input logic sub = 0,
                        input logic ovr_en = 0, input logic [32:0] ovr = 0,
                        input logic c1 = 0, input logic c3 = 0);
        logic [32:0] exp, r, g1, g3;
        rst = rst_v; en = en_v; A = a; B = b; Ci = ci; Subtract = sub;
        exp = model_ref(a, b, ci, sub);
        r   = ovr_en ? ovr : exp;
        res1[cyc] = r ^ {32'd0, c1};
        res3[cyc] = r ^ {32'd0, c3};
        g1 = (cyc >= 1) ? res1[cyc-1] : 33'd0;
        g3 = (cyc >= 3) ? res3[cyc-3] : 33'd0;
        {Co1, S1} = g1;
        {Co3, S3} = g3;
        model_edge(0, g1, en_v, exp, rst_v);
        model_edge(1, g3, en_v, exp, rst_v);
        @(posedge clk);
        #1;
        check_inst(0, cv1, mm1, chk1, err1, fexp1, fgot1, fv1, hl1);
        check_inst(1, cv3, mm3, chk3, err3, fexp3, fgot3, fv3, hl3);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        rst = 1'b1; en = 1'b0; A = '0; B = '0; Ci = 1'b0; Subtract = 1'b0;
        S1 = '0; Co1 = 1'b0; S3 = '0; Co3 = 1'b0;

        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // Basic add against a hard-coded DUT answer
        step(1'b0, 1'b1, 32'd10, 32'd20, 1'b0, 1'b0, 1'b1, {1'b0, 32'd30});
        step(1'b0, 1'b0);
        check_eq("basic_cv", 64'(cv1), 64'd1);
        check_eq("basic_mm", 64'(mm1), 64'd0);
        check_eq("basic_chk", 64'(chk1), 64'd1);
        check_eq("basic_err", 64'(err1), 64'd0);
        idle(3);

        // Spec-given results as DUT answers; any disagreement shows as a mismatch
        step(1'b0, 1'b1, 32'd10, 32'd20, 1'b1, 1'b1, 1'b1, {1'b0, 32'hFFFF_FFF6});
        step(1'b0, 1'b1, 32'd20, 32'd10, 1'b1, 1'b1, 1'b1, {1'b1, 32'd10});
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, {1'b1, 32'h0});
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b1, {1'b1, 32'h1});
        idle(4);
        check_eq("bound_chk1", 64'(chk1), 64'd5);
        check_eq("bound_err1", 64'(err1), 64'd0);
        check_eq("bound_chk3", 64'(chk3), 64'd5);
        check_eq("bound_err3", 64'(err3), 64'd0);

        // Injected error on the 2nd of 4 back-to-back transactions
        step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0, 33'd0,
                 (i == 1));
        end
        idle(4);
        check_eq("inj_chk", 64'(chk1), 64'd2);
        check_eq("inj_err", 64'(err1), 64'd1);
        check_eq("inj_halted", 64'(hl1), 64'd1);
        check_eq("inj_first_valid", 64'(fv1), 64'd1);
        check_eq("inj_first_diff", 64'(fexp1 ^ fgot1), 64'd1);

        // Latency 3 with an en gap
        step(1'b1, 1'b0);
        step(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1, $urandom, $urandom, 1'b1, 1'b1);
        step(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b1);
        idle(5);
        check_eq("gap_chk3", 64'(chk3), 64'd3);
        check_eq("gap_err3", 64'(err3), 64'd0);

        // Reset one cycle after a capture
        step(1'b1, 1'b0);
        step(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
        step(1'b1, 1'b0);
        idle(5);
        check_eq("rstmid_chk3", 64'(chk3), 64'd0);
        check_eq("rstmid_fv3", 64'(fv3), 64'd0);
        check_eq("rstmid_halt3", 64'(hl3), 64'd0);

        // Random traffic with occasional corruption and resets
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 pick_operand(), pick_operand(), 1'($urandom), 1'($urandom), 1'b0, 33'd0,
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0));
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
